addsub_seq: RTL
===============

# addsub_seq

Parametrised, multi-cycle two's-complement adder/subtractor with valid/ready handshakes and status flags. It generalises the team's fixed 4-bit ripple add/sub to any operand width. Carry propagation runs CHUNK bits per clock, so the critical path stays short for wide operands. It sits between an operand source and a result consumer, and accepts one operation at a time.

## Interface
- WIDTH, 16: operand/result width in bits; must be >= 2.
- CHUNK, 4: bits processed per RUN cycle; 1 <= CHUNK <= WIDTH, and WIDTH % CHUNK == 0. NCHUNK = WIDTH/CHUNK.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  minuend/addend.
- b  in  WIDTH  subtrahend/addend.
- m  in  1  mode: 0 = a+b, 1 = a-b (computed as a + ~b + 1).
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes result.
- s  out  WIDTH  result.
- c  out  1  carry out of MSB (for subtract: 1 = no borrow).
- v  out  1  signed overflow.
- z  out  1  s == 0.
- n  out  1  s[WIDTH-1].

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch a, b XOR {WIDTH{m}}, carry = m, sign of a, idx = 0 -> RUN.
- RUN:
  - Each cycle, add chunk idx of latched a, chunk idx of latched b', and the running carry.
  - Write the sum into s bits [idx*CHUNK +: CHUNK] and update carry; idx++.
  - On the last chunk (idx == NCHUNK-1), capture carry into the MSB (cin_msb) and carry out -> DONE.
- DONE:
  - out_valid = 1; s, c, v, z, n are stable.
  - On out_ready -> IDLE. in_ready stays 0 in DONE.
- Flags, computed on the final RUN cycle and registered:
  - c = final carry.
  - v = cin_msb XOR c.
  - z = (final s == 0).
  - n = final s[WIDTH-1].
- Arithmetic is modulo 2^WIDTH unless ADDSUB_SAT_EN is defined.
- Inputs a, b and m are sampled only on the accept edge; changes at any other time are ignored.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.

## Timing
- Reset (asynchronous, active-low):
  - state = IDLE.
  - s = 0, c = 0, v = 0, z = 0, n = 0, out_valid = 0, idx = 0.
  - in_ready reads 1 (state decode), but no transfer occurs while rst_n = 0.
- Latency: with the accept edge as T, out_valid rises after edge T+NCHUNK.
- CHUNK = WIDTH gives a single RUN cycle; out_valid rises after edge T+1.
- Throughput: one operation per NCHUNK+2 cycles when out_ready is held high (1 accept cycle, NCHUNK RUN, 1 DONE).
- Backpressure: DONE holds indefinitely with outputs unchanged until out_ready = 1. Return to IDLE takes one edge.
- Reset mid-RUN or mid-DONE: the operation is abandoned immediately and outputs take reset values. No partial result is ever presented.
- out_valid, in_ready and all results are registered or pure state decodes; there is no combinational path from in_valid or out_ready to any output.

## Configuration
- ADDSUB_SAT_EN defined:
  - When v = 1, s is replaced by the signed saturation value: 0 followed by WIDTH-1 ones (max positive) if the latched a was non-negative, otherwise 1 followed by WIDTH-1 zeros (max negative).
  - v still reports 1; c is unchanged; z and n reflect the saturated s.
  - The saturation mux applies on the final RUN cycle only; latency is unchanged.
- ADDSUB_SAT_EN undefined: s wraps modulo 2^WIDTH and no saturation logic is built.

## Test plan
All scenarios use WIDTH=16, CHUNK=4.
- Add: a=0x1234, b=0x0FFF, m=0 -> s=0x2233, c=0, v=0, z=0, n=0. out_valid first high exactly 4 edges after the accept edge.
- Subtract with borrow: a=0x0005, b=0x0007, m=1 -> s=0xFFFE, c=0, v=0, n=1.
- Signed overflow: a=0x7FFF, b=0x0001, m=0 -> without macro s=0x8000, v=1, n=1; with ADDSUB_SAT_EN s=0x7FFF, v=1, n=0, c=0. Also a=0x8000, b=0x0001, m=1 -> wrap s=0x7FFF / sat s=0x8000, v=1.
- Equal subtract: a=0xABCD, b=0xABCD, m=1 -> s=0x0000, z=1, c=1, v=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid, a and b -> s and flags stable, in_ready=0, no new accept. Raise out_ready -> IDLE next edge, in_ready=1.
- Reset mid-RUN: assert rst_n=0 two cycles after accept -> out_valid, s and flags go to 0 immediately. After release, a fresh 0x0001+0x0001 gives s=0x0002.

Source files
------------

// File: rtl/addsub_seq_if.sv
// Operand/result bus for addsub_seq.
// Both channels use valid/ready: a transfer happens on a rising clk edge where
// valid and ready are both high; the producer holds its payload stable while
// valid is high and ready is low, and ready never depends combinationally on
// valid.
interface addsub_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             m;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c;
  logic             v;
  logic             z;
  logic             n;

  // Operand source and result consumer side.
  modport master (
    output in_valid, a, b, m, out_ready,
    input  in_ready, out_valid, s, c, v, z, n
  );

  // Adder/subtractor side.
  modport slave (
    input  in_valid, a, b, m, out_ready,
    output in_ready, out_valid, s, c, v, z, n
  );
endinterface

// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle two's-complement adder/subtractor.
// Carry ripples CHUNK bits per clock through NCHUNK RUN cycles, then the
// result and c/v/z/n flags are held in DONE until the consumer takes them.
// Optional feature: define ADDSUB_SAT_EN to saturate s on signed overflow.
module addsub_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  addsub_seq_if.slave bus,
  output logic [1:0] dbg_state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] CMASK    = {WIDTH{1'b1}} >> (WIDTH - CHUNK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              c_q, c_d;
  logic              v_q, v_d;
  logic              z_q, z_d;
  logic              n_q, n_d;
`ifdef ADDSUB_SAT_EN
  logic              a_neg_q, a_neg_d;
`endif

  // Per-chunk datapath signals.
  logic [31:0]       base;
  logic [CHUNK-1:0]  a_ch;
  logic [CHUNK-1:0]  b_ch;
  logic [CHUNK:0]    csum;
  logic [WIDTH-1:0]  s_wrap;
  logic [WIDTH-1:0]  s_fin;
  logic              cin_msb;
  logic              v_fin;

  // Handshake outputs are pure state decodes; results come straight from flops.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.s         = s_q;
  assign bus.c         = c_q;
  assign bus.v         = v_q;
  assign bus.z         = z_q;
  assign bus.n         = n_q;
  assign dbg_state     = state_q;

  // Chunk adder, result merge, flag derivation and FSM next state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    s_d     = s_q;
    c_d     = c_q;
    v_d     = v_q;
    z_d     = z_q;
    n_d     = n_q;
`ifdef ADDSUB_SAT_EN
    a_neg_d = a_neg_q;
`endif

    base   = 32'(idx_q) * CHUNK;
    a_ch   = CHUNK'(a_q >> base);
    b_ch   = CHUNK'(b_q >> base);
    csum   = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
    s_wrap = (s_q & ~(CMASK << base)) | (WIDTH'(csum[CHUNK-1:0]) << base);
    // Sum bit = a ^ b ^ cin, so the carry into the MSB falls out of the XOR.
    cin_msb = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ s_wrap[WIDTH-1];
    v_fin   = cin_msb ^ csum[CHUNK];
    s_fin   = s_wrap;
`ifdef ADDSUB_SAT_EN
    if (v_fin) begin
      s_fin = a_neg_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b ^ {WIDTH{bus.m}};
          carry_d = bus.m;
          idx_d   = '0;
`ifdef ADDSUB_SAT_EN
          a_neg_d = bus.a[WIDTH-1];
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = csum[CHUNK];
        if (idx_q == LAST_IDX) begin
          s_d     = s_fin;
          c_d     = csum[CHUNK];
          v_d     = v_fin;
          z_d     = (s_fin == '0);
          n_d     = s_fin[WIDTH-1];
          idx_d   = '0;
          state_d = DONE;
        end else begin
          s_d   = s_wrap;
          idx_d = idx_q + IDXW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand and result registers; reset abandons any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
`ifdef ADDSUB_SAT_EN
      a_neg_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      c_q     <= c_d;
      v_q     <= v_d;
      z_q     <= z_d;
      n_q     <= n_d;
`ifdef ADDSUB_SAT_EN
      a_neg_q <= a_neg_d;
`endif
    end
  end

endmodule
